// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit                                              |
// | Description : Single-outstanding load/store unit between decode and a      |
// |               word-wide memory port. Places store data on byte lanes,      |
// |               extracts and extends load data, flags illegal accesses and   |
// |               times out when memory never acknowledges.                    |
// | Option      : LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword and |
// |               word accesses complete with err instead of being aligned.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // Last wait-count value seen before the timeout edge, so mem_req is high
  // for exactly MAX_WAIT cycles when no ack arrives.
  localparam logic [7:0] c_WAIT_LIMIT = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } t_state;

  t_state      r_state;
  logic [7:0]  r_wait;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_err;

  logic        w_req;
  logic        w_is_store;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_legal;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  assign w_req      = memread | memwrite;
  // A simultaneous read and write request is handled as a store.
  assign w_is_store = memwrite;

  // Stores only have B/H/W encodings; loads add the unsigned B/H variants.
  assign w_f3_ok = w_is_store ? (!funct3[2] && (funct3[1:0] != 2'b11))
                              : ((funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111));

  assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_legal = w_f3_ok && !w_misalign;
  assign w_off   = addr[1:0];
`else
  // Misaligned accesses are silently aligned down within the word.
  assign w_legal = w_f3_ok;
  assign w_off   = (funct3[1:0] == 2'b10) ? 2'b00 :
                   (funct3[1:0] == 2'b01) ? {addr[1], 1'b0} : addr[1:0];
`endif

  // Store lane placement: enables select the lanes, data is replicated.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata;
      end
    endcase
  end

  // Load lane selection from the captured offset, then sign/zero extension.
  always_comb begin
    w_byte     = 8'h00;
    w_load_val = mem_rdata;
    case (r_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_f3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'h0, w_byte};
      3'b101:  w_load_val = {16'h0, w_half};
      default: w_load_val = mem_rdata;
    endcase
  end

  // Access FSM with all memory-side and completion outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wait      <= 8'd0;
      r_off       <= 2'd0;
      r_f3        <= 3'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
          if (w_req) begin
            if (w_legal) begin
              r_state     <= ST_REQ;
              r_wait      <= 8'd0;
              r_off       <= w_off;
              r_f3        <= funct3;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_store;
              r_mem_addr  <= {addr[31:2], 2'b00};
              r_mem_be    <= w_is_store ? w_be : 4'b1111;
              r_mem_wdata <= w_is_store ? w_wdata : 32'd0;
            end else begin
              // Illegal access completes immediately without touching memory.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            // Ack takes priority over a timeout in the same cycle.
            r_state   <= ST_DONE;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b0;
            r_rdata   <= r_mem_we ? 32'd0 : w_load_val;
          end else if (r_wait == c_WAIT_LIMIT) begin
            r_state   <= ST_DONE;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_rdata   <= 32'd0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall     = rst_n & (((r_state == ST_IDLE) & w_req) | (r_state == ST_REQ));
  assign rdata     = r_rdata;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                           |
// | Description : Directed self-checking bench for load_store_unit with a      |
// |               scoreboard of expected completions (MAX_WAIT = 4).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    int          reqc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .memread   (memread),
    .memwrite  (memwrite),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic e, input logic [31:0] ma,
                              input logic [3:0] be, input logic [31:0] wd, input logic we,
                              input int reqc, input int lat);
    exp_t x;
    x.rdata = rd; x.err = e; x.maddr = ma; x.be = be; x.wd = wd; x.we = we;
    x.reqc = reqc; x.lat = lat;
    return x;
  endfunction

  // Present one request, scramble inputs after capture, answer with ack after
  // ack_after REQ cycles (-1 = never) and compare the completion.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                        input int ack_after, input exp_t e);
    int   n_req;
    int   cyc;
    bit   seen;
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
    mem_rdata = mrd; mem_ack = 1'b0;
    #1 check({tag, ".stall_req"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0; funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = ~wd;
    n_req = 0; cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (done) begin
        seen = 1;
      end else if (mem_req) begin
        check({tag, ".mem_addr"}, mem_addr, sb[0].maddr);
        check({tag, ".mem_be"}, 32'(mem_be), 32'(sb[0].be));
        check({tag, ".mem_we"}, 32'(mem_we), 32'(sb[0].we));
        if (sb[0].we) check({tag, ".mem_wdata"}, mem_wdata, sb[0].wd);
        check({tag, ".stall_busy"}, 32'(stall), 32'd1);
        mem_ack = (n_req == ack_after);
        n_req++;
      end
    end
    mem_ack = 1'b0;
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    x = sb.pop_front();
    if (seen) begin
      check({tag, ".rdata"}, rdata, x.rdata);
      check({tag, ".err"}, 32'(err), 32'(x.err));
      check({tag, ".req_cycles"}, n_req, x.reqc);
      check({tag, ".latency"}, cyc, x.lat);
      check({tag, ".mem_req_after"}, 32'(mem_req), 32'd0);
      check({tag, ".stall_done"}, 32'(stall), 32'd0);
    end
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".err_clear"}, 32'(err), 32'd0);
  endtask

  initial begin
    // Reset with a request pending: stall must stay low, outputs zero.
    rst_n = 1'b0; memread = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_be", 32'(mem_be), 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    memread = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("idle.stall", 32'(stall), 32'd0);

    access("lb", 1, 0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FFFF, 0,
           mk(32'hFFFF_FF80, 0, 32'h0000_0100, 4'hF, 32'd0, 0, 1, 2));
    access("sh", 0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 2,
           mk(32'd0, 0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 1, 3, 4));
    access("lw_timeout", 1, 0, 3'b010, 32'h0000_0040, 32'd0, 32'h1111_1111, -1,
           mk(32'd0, 1, 32'h0000_0040, 4'hF, 32'd0, 0, MW, MW + 1));
`ifdef LSU_MISALIGN_TRAP_EN
    access("lhu_mis", 1, 0, 3'b101, 32'h0000_0001, 32'd0, 32'hDEAD_BEEF, 0,
           mk(32'd0, 1, 32'd0, 4'hF, 32'd0, 0, 0, 1));
    access("lw_mis", 1, 0, 3'b010, 32'h0000_0023, 32'd0, 32'hA1B2_C3D4, 0,
           mk(32'd0, 1, 32'd0, 4'hF, 32'd0, 0, 0, 1));
`else
    access("lhu_mis", 1, 0, 3'b101, 32'h0000_0001, 32'd0, 32'hDEAD_BEEF, 0,
           mk(32'h0000_BEEF, 0, 32'h0000_0000, 4'hF, 32'd0, 0, 1, 2));
    access("lw_mis", 1, 0, 3'b010, 32'h0000_0023, 32'd0, 32'hA1B2_C3D4, 0,
           mk(32'hA1B2_C3D4, 0, 32'h0000_0020, 4'hF, 32'd0, 0, 1, 2));
`endif
    access("ld_f3_011", 1, 0, 3'b011, 32'h0000_0010, 32'd0, 32'h0000_0000, 0,
           mk(32'd0, 1, 32'd0, 4'hF, 32'd0, 0, 0, 1));
    access("sb", 0, 1, 3'b000, 32'h0000_0305, 32'h0000_00A5, 32'h0, 1,
           mk(32'd0, 0, 32'h0000_0304, 4'b0010, 32'hA5A5_A5A5, 1, 2, 3));
    access("lh", 1, 0, 3'b001, 32'h0000_0086, 32'd0, 32'h8001_1234, 0,
           mk(32'hFFFF_8001, 0, 32'h0000_0084, 4'hF, 32'd0, 0, 1, 2));
    access("lbu", 1, 0, 3'b100, 32'h0000_0081, 32'd0, 32'h1234_5678, 0,
           mk(32'h0000_0056, 0, 32'h0000_0080, 4'hF, 32'd0, 0, 1, 2));
    access("sw_rw", 1, 1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h7777_7777, 0,
           mk(32'd0, 0, 32'h0000_0010, 4'hF, 32'hCAFE_F00D, 1, 1, 2));
    access("st_f3_100", 0, 1, 3'b100, 32'h0000_0010, 32'h1, 32'h0, 0,
           mk(32'd0, 1, 32'd0, 4'hF, 32'd0, 1, 0, 1));
    access("ack_at_limit", 1, 0, 3'b010, 32'h0000_0020, 32'd0, 32'h1122_3344, MW - 1,
           mk(32'h1122_3344, 0, 32'h0000_0020, 4'hF, 32'd0, 0, MW, MW + 1));

    // Reset pulse in the middle of a pending access.
    @(negedge clk);
    memread = 1'b1; funct3 = 3'b010; addr = 32'h0000_0044;
    @(posedge clk); #1;
    memread = 1'b0;
    @(negedge clk);
    check("rst_mid.in_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid.mem_req", 32'(mem_req), 32'd0);
    check("rst_mid.stall_low", 32'(stall), 32'd0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_mid.idle_req", 32'(mem_req), 32'd0);
      check("rst_mid.idle_stall", 32'(stall), 32'd0);
      check("rst_mid.idle_done", 32'(done), 32'd0);
    end
    access("after_rst", 1, 0, 3'b000, 32'h0000_0002, 32'd0, 32'h0042_0000, 0,
           mk(32'h0000_0042, 0, 32'h0000_0000, 4'hF, 32'd0, 0, 1, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MAX_WAIT, default 255: cycles in REQ without mem_ack before timeout; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 memread  input  1  load request from decode.
REQ-005 memwrite  input  1  store request from decode.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address from ALU.
REQ-008 wdata  input  32  store data (rs2).
REQ-009 rdata  output  32  extended load result, valid while done=1.
REQ-010 stall  output  1  holds the pipeline while an access is pending.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  with done: illegal funct3, timeout or misalignment.
REQ-013 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-014 mem_addr  output  32  word-aligned address; bits [1:0] always 0.
REQ-015 mem_be  output  4  byte enables; mem_wdata  output  32  lane-placed store data.
REQ-016 mem_rdata  input  32; mem_ack  input  1  memory completes the access in the cycle mem_ack=1.

Function
REQ-017 FSM states: IDLE, REQ, DONE. IDLE to REQ when memread|memwrite and the access is legal. IDLE to DONE with err=1 when the access is illegal. REQ to DONE on mem_ack or timeout. DONE to IDLE unconditionally.
REQ-018 In IDLE with a request present: stall=1 combinationally. In REQ: stall=1. In DONE and in IDLE with no request: stall=0.
REQ-019 Inputs are captured at the IDLE exit edge; later input changes do not affect the access in flight.
REQ-020 memread and memwrite both high: treated as a store.
REQ-021 funct3 011, 110 or 111 on a load, or funct3 with bit 2 set on a store: illegal. No memory access occurs; done=1, err=1, rdata=0.
REQ-022 In REQ: mem_req=1, with mem_we, mem_addr={addr[31:2],2'b00}, mem_be and mem_wdata held constant until the ack cycle. mem_req=0 in the cycle after ack.
REQ-023 Store lanes:
- SB: be=1<<addr[1:0]; byte replicated to all four lanes.
- SH: be=addr[1]?1100:0011; halfword replicated to both halves.
- SW: be=1111.
REQ-024 Loads drive mem_be=1111. On ack, the lane is selected by addr[1:0], then sign-extended (B/H) or zero-extended (BU/HU) into rdata, which is registered and presented in DONE.
REQ-025 Wait counter clears on REQ entry and increments each REQ cycle without ack. When it reaches MAX_WAIT: drop mem_req, enter DONE with err=1, rdata=0.
REQ-026 Ack and timeout in the same cycle: ack wins, err=0.
REQ-027 rdata is 0 after stores. done and err are 0 outside DONE.
REQ-028 Latency: with ack in the first REQ cycle, done asserts 2 cycles after the request is presented.

Reset
REQ-029 rst_n=0 at an edge forces IDLE regardless of state, including mid-REQ.
REQ-030 The wait counter clears to 0 on reset.
REQ-031 All registered outputs reset to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, done, err.
REQ-032 stall=0 while rst_n=0.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1, or word with addr[1:0]!=0, is illegal per REQ-021 (no memory access, done=1, err=1).
REQ-034 Macro LSU_MISALIGN_TRAP_EN undefined: low address bits are forced aligned (H clears addr[0], W clears addr[1:0]) and the access proceeds with err=0.

Verification
REQ-035 LB at addr 0x103, mem_rdata 0x80FF_FFFF, ack in first REQ cycle -> done at cycle 2, rdata 0xFFFF_FF80, mem_addr 0x100, err=0.
REQ-036 SH at addr 0x202, wdata 0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata 0xABCD_ABCD, mem_addr 0x200.
REQ-037 LW with mem_ack never asserted, MAX_WAIT=4 -> mem_req high 4 cycles, then done=1, err=1, rdata=0.
REQ-038 LHU at addr 0x1 -> with macro: no mem_req, done=1, err=1. Without macro: mem_addr 0x0, rdata=mem_rdata[15:0] zero-extended.
REQ-039 rst_n low for one edge during REQ -> next cycle: state IDLE, mem_req=0, stall=0 until a new request.
REQ-040 Load with funct3=011 -> no mem_req, done=1, err=1 in the cycle after the request.
